// File: rtl/buff_arb_pkg.sv
// ---------------------------------------------------------------------------
// buff_arb_pkg
// Shared types and constants for the two-client buffer-memory read arbiter.
//   arb_state_t  : arbiter FSM state (IDLE -> ISSUE -> WAIT -> IDLE)
//   CLI_TAPE/AUX : client indices (0 = CAS tape player, 1 = auxiliary reader)
//   TIMEOUT_FILL : data returned to a client whose read was force-completed
//   ADDR_W       : byte address width of the buffer port
// ---------------------------------------------------------------------------
package buff_arb_pkg;

    localparam int ADDR_W = 27;

    localparam logic CLI_TAPE = 1'b0;
    localparam logic CLI_AUX  = 1'b1;

    localparam logic [7:0] TIMEOUT_FILL = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/buff_arb_client.sv
// ---------------------------------------------------------------------------
// buff_arb_client
// Per-client front end of the buffer arbiter. Turns the client's rising-edge
// read request into a pending flag with a latched address, and holds the read
// data delivered by the arbiter until the client's next completion.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   rd, a        : client read request (rising edge) and byte address
//   done         : completion strobe from the arbiter (only while pend is set)
//   done_data    : data to hold on completion
//   pend         : request captured and not yet completed
//   addr         : address latched at capture
//   di           : held read data
//   ready        : client idle / data valid
// ---------------------------------------------------------------------------
module buff_arb_client
    import buff_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rd,
    input  logic [ADDR_W-1:0] a,
    input  logic              done,
    input  logic [7:0]        done_data,
    output logic              pend,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        di,
    output logic              ready
);

    logic rd_q;
    logic rise;

    assign rise  = rd & ~rd_q;
    // Ready is exactly "no outstanding request": it drops on capture and
    // returns in the same cycle the held data is updated.
    assign ready = ~pend;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q <= 1'b0;
            pend <= 1'b0;
            addr <= '0;
            di   <= '0;
        end else begin
            rd_q <= rd;
            // done only arrives while pend is set, and capture requires pend
            // clear, so the two branches never compete for the same request.
            if (done) begin
                pend <= 1'b0;
                di   <= done_data;
            end else if (rise && !pend) begin
                pend <= 1'b1;
                addr <= a;
            end
        end
    end

endmodule

// File: rtl/buff_mem_arb.sv
// ---------------------------------------------------------------------------
// buff_mem_arb
// Two-port read arbiter in front of the shared byte-wide buffer memory port.
// Client 0 (tape) and client 1 (aux reader) each keep their direct-wired read
// handshake; this block captures requests, issues one downstream read at a
// time, holds the returned data per client and force-completes reads that
// never see mem_ready (data 8'hFF, sticky err_timeout).
//
// Parameters:
//   TIMEOUT : WAIT cycles before a forced completion (1..65535)
//   BLANK   : cycles after mem_rd during which mem_ready is ignored (1..7)
// Build option:
//   BUFF_ARB_RR_EN defined   -> round-robin when both clients are pending
//   BUFF_ARB_RR_EN undefined -> fixed priority, client 0 always wins
// Ports:
//   clk, reset_n                : clock, asynchronous active-low reset
//   c0_a/c0_rd/c0_di/c0_ready   : client 0 address, request, data, ready
//   c1_a/c1_rd/c1_di/c1_ready   : client 1 address, request, data, ready
//   mem_a/mem_rd                : downstream address and one-cycle read strobe
//   mem_di/mem_ready            : downstream read data and idle/data-valid
//   err_timeout                 : sticky forced-completion flag
// ---------------------------------------------------------------------------
module buff_mem_arb
    import buff_arb_pkg::*;
#(
    parameter int TIMEOUT = 4096,
    parameter int BLANK   = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] c0_a,
    input  logic              c0_rd,
    output logic [7:0]        c0_di,
    output logic              c0_ready,
    input  logic [ADDR_W-1:0] c1_a,
    input  logic              c1_rd,
    output logic [7:0]        c1_di,
    output logic              c1_ready,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_rd,
    input  logic [7:0]        mem_di,
    input  logic              mem_ready,
    output logic              err_timeout
);

    localparam logic [2:0]  BLANK_LOAD = 3'(BLANK - 1);
    localparam logic [15:0] WDOG_LOAD  = 16'(TIMEOUT - 1);

    arb_state_t        state, state_nxt;
    logic              c0_pend, c1_pend;
    logic [ADDR_W-1:0] c0_addr, c1_addr;
    logic              win;
    logic              sel;
    logic              grant;
    logic              complete;
    logic              forced;
    logic [2:0]        blank_cnt;
    logic [15:0]       wdog;
    logic [7:0]        done_data;
    logic              c0_done, c1_done;

    assign done_data = forced ? TIMEOUT_FILL : mem_di;
    assign c0_done   = complete && (win == CLI_TAPE);
    assign c1_done   = complete && (win == CLI_AUX);

    buff_arb_client u_c0 (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd        (c0_rd),
        .a         (c0_a),
        .done      (c0_done),
        .done_data (done_data),
        .pend      (c0_pend),
        .addr      (c0_addr),
        .di        (c0_di),
        .ready     (c0_ready)
    );

    buff_arb_client u_c1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd        (c1_rd),
        .a         (c1_a),
        .done      (c1_done),
        .done_data (done_data),
        .pend      (c1_pend),
        .addr      (c1_addr),
        .di        (c1_di),
        .ready     (c1_ready)
    );

`ifdef BUFF_ARB_RR_EN
    // Client granted most recently; resets to client 1 so that client 0
    // wins the first contested grant.
    logic last_grant;

    always_comb begin
        if (c0_pend && c1_pend) sel = ~last_grant;
        else                    sel = c0_pend ? CLI_TAPE : CLI_AUX;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   last_grant <= CLI_AUX;
        else if (grant) last_grant <= sel;
    end
`else
    always_comb begin
        sel = c0_pend ? CLI_TAPE : CLI_AUX;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        complete  = 1'b0;
        forced    = 1'b0;
        case (state)
            IDLE: begin
                if (c0_pend || c1_pend) begin
                    grant     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                // A genuine completion on the watchdog's last cycle wins
                // over the forced one.
                if (blank_cnt == '0 && mem_ready) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end else if (wdog == '0) begin
                    complete  = 1'b1;
                    forced    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win         <= CLI_TAPE;
            mem_a       <= '0;
            mem_rd      <= 1'b0;
            blank_cnt   <= '0;
            wdog        <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (grant) begin
                win    <= sel;
                mem_a  <= (sel == CLI_AUX) ? c1_addr : c0_addr;
                mem_rd <= 1'b1;
            end
            if (state == ISSUE) begin
                mem_rd    <= 1'b0;
                blank_cnt <= BLANK_LOAD;
                wdog      <= WDOG_LOAD;
            end
            if (state == WAIT && !complete) begin
                if (blank_cnt != '0) blank_cnt <= blank_cnt - 3'd1;
                wdog <= wdog - 16'd1;
            end
            if (forced) err_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_buff_mem_arb.sv
// ---------------------------------------------------------------------------
// tb_buff_mem_arb
// Self-checking bench for buff_mem_arb (default build, fixed priority).
// A behavioural buffer memory answers each mem_rd after a programmable delay
// with data from a byte table; expected client data, grant order, request
// latency and watchdog behaviour are computed from the arbiter's rules.
// ---------------------------------------------------------------------------
module tb_buff_mem_arb;

    localparam int TMO = 16;
    localparam int BLK = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [26:0] c0_a, c1_a, mem_a;
    logic        c0_rd, c1_rd, mem_rd, mem_ready;
    logic        c0_ready, c1_ready, err_timeout;
    logic [7:0]  c0_di, c1_di, mem_di;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem_model [256];
    int          resp_lat;
    bit          resp_stuck;
    int          rd_pulses;
    logic [26:0] seen_q [$];
    logic [7:0]  exp_di0, exp_di1;

    always #5 clk = ~clk;

    buff_mem_arb #(.TIMEOUT(TMO), .BLANK(BLK)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .c0_a        (c0_a),
        .c0_rd       (c0_rd),
        .c0_di       (c0_di),
        .c0_ready    (c0_ready),
        .c1_a        (c1_a),
        .c1_rd       (c1_rd),
        .c1_di       (c1_di),
        .c1_ready    (c1_ready),
        .mem_a       (mem_a),
        .mem_rd      (mem_rd),
        .mem_di      (mem_di),
        .mem_ready   (mem_ready),
        .err_timeout (err_timeout)
    );

    // Behavioural buffer memory: on a mem_rd it drops ready, scrambles the
    // data bus, and after resp_lat further cycles presents table data.
    int          cnt;
    logic [26:0] cur;
    initial begin
        mem_ready = 1'b1;
        mem_di    = 8'h00;
        cnt       = -1;
        cur       = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                cnt       = -1;
                mem_ready = 1'b1;
            end else if (mem_rd) begin
                mem_ready = 1'b0;
                mem_di    = 8'($urandom);
                rd_pulses++;
                seen_q.push_back(mem_a);
                cur = mem_a;
                cnt = resp_stuck ? -2 : resp_lat;
            end else if (cnt == -2) begin
                if (!resp_stuck) begin
                    mem_ready = 1'b1;
                    cnt       = -1;
                end
            end else if (cnt > 0) begin
                cnt--;
            end else if (cnt == 0) begin
                mem_di    = mem_model[cur[7:0]];
                mem_ready = 1'b1;
                cnt       = -1;
            end
        end
    end

    // Cycles from a request edge to its completion edge, single client.
    function automatic int req_latency(input int lat);
        return (lat + 3 > 2 + BLK) ? lat + 3 : 2 + BLK;
    endfunction

    task automatic wait_ready(input bit w0, input bit w1, input int budget,
                              output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if ((!w0 || c0_ready) && (!w1 || c1_ready)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        c0_rd = 1'b0; c1_rd = 1'b0; c0_a = '0; c1_a = '0;
        resp_lat = 0; resp_stuck = 1'b0; rd_pulses = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        exp_di0 = 8'h00; exp_di1 = 8'h00;
        checks++;
        if ({c0_ready, c1_ready, c0_di, c1_di, mem_a, mem_rd, err_timeout} !==
            {1'b1, 1'b1, 8'h00, 8'h00, 27'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b%b di=%h/%h a=%h rd=%b err=%b exp 11 00/00 0 0 0",
                     c0_ready, c1_ready, c0_di, c1_di, mem_a, mem_rd, err_timeout);
        end
    endtask

    task automatic test_single_read();
        int n; bit ok;
        mem_model[8'h10] = 8'hA5;
        resp_lat = 5;
        rd_pulses = 0; seen_q.delete();
        c0_a = 27'h10; c0_rd = 1'b1;
        @(negedge clk);
        checks++;
        if ({c0_ready, mem_rd} !== 2'b00) begin
            errors++;
            $display("FAIL single_capture: got ready=%b mem_rd=%b exp 0 0", c0_ready, mem_rd);
        end
        @(negedge clk);
        checks++;
        if ({mem_rd, mem_a} !== {1'b1, 27'h10}) begin
            errors++;
            $display("FAIL single_issue: got mem_rd=%b mem_a=%h exp 1 0000010", mem_rd, mem_a);
        end
        wait_ready(1'b1, 1'b0, 100, n, ok);
        checks++;
        if (!ok || n !== req_latency(5) - 1) begin
            errors++;
            $display("FAIL single_latency: got ok=%b n=%0d exp n=%0d", ok, n, req_latency(5) - 1);
        end
        exp_di0 = 8'hA5;
        checks++;
        if ({rd_pulses, c0_di, c1_di} !== {32'd1, exp_di0, exp_di1}) begin
            errors++;
            $display("FAIL single_data: got pulses=%0d c0_di=%h c1_di=%h exp 1 %h %h",
                     rd_pulses, c0_di, c1_di, exp_di0, exp_di1);
        end
        c0_rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_priority();
        int n; bit ok;
        logic [53:0] got_order;
        mem_model[8'h20] = 8'($urandom);
        mem_model[8'h30] = 8'($urandom);
        resp_lat = $urandom_range(0, 6);
        rd_pulses = 0; seen_q.delete();
        c0_a = 27'h20; c1_a = 27'h30;
        c0_rd = 1'b1; c1_rd = 1'b1;
        wait_ready(1'b1, 1'b1, 200, n, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL prio_done: got no completion in %0d cycles exp both ready", n);
        end
        got_order = (seen_q.size() == 2) ? {seen_q[0], seen_q[1]} : 54'h0;
        checks++;
        if (got_order !== {27'h20, 27'h30}) begin
            errors++;
            $display("FAIL prio_order: got %h (n=%0d) exp 0000020,0000030", got_order, seen_q.size());
        end
        exp_di0 = mem_model[8'h20];
        exp_di1 = mem_model[8'h30];
        checks++;
        if ({c0_di, c1_di} !== {exp_di0, exp_di1}) begin
            errors++;
            $display("FAIL prio_data: got %h/%h exp %h/%h", c0_di, c1_di, exp_di0, exp_di1);
        end
        c0_rd = 1'b0; c1_rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_held();
        int n; bit ok;
        logic [26:0] a;
        a = 27'($urandom);
        resp_lat = 3;
        rd_pulses = 0;
        c0_a = a; c0_rd = 1'b1;
        repeat (50) @(negedge clk);
        wait_ready(1'b1, 1'b0, 50, n, ok);
        c0_rd = 1'b0;
        @(negedge clk);
        exp_di0 = mem_model[a[7:0]];
        checks++;
        if (!ok || rd_pulses !== 1 || c0_di !== exp_di0) begin
            errors++;
            $display("FAIL held_once: got ok=%b pulses=%0d di=%h exp 1 1 %h", ok, rd_pulses, c0_di, exp_di0);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            int mode; int n; bit ok; bit w0; bit w1;
            logic [26:0] a0, a1;
            mode = $urandom_range(0, 3);
            a0 = 27'($urandom); a1 = 27'($urandom);
            resp_lat = $urandom_range(0, 12);
            rd_pulses = 0; seen_q.delete();
            w0 = (mode != 1); w1 = (mode != 0);
            c0_a = a0; c1_a = a1;
            case (mode)
                0: c0_rd = 1'b1;
                1: c1_rd = 1'b1;
                2: begin c0_rd = 1'b1; c1_rd = 1'b1; end
                default: begin
                    c1_rd = 1'b1;
                    repeat ($urandom_range(1, 6)) @(negedge clk);
                    c0_rd = 1'b1;
                end
            endcase
            wait_ready(w0, w1, 200, n, ok);
            checks++;
            if (!ok || rd_pulses !== int'(w0) + int'(w1)) begin
                errors++;
                $display("FAIL rand_done[%0d]: got ok=%b pulses=%0d exp 1 %0d", it, ok, rd_pulses, int'(w0) + int'(w1));
            end
            if (mode < 2) begin
                checks++;
                if (n !== req_latency(resp_lat) + 1) begin
                    errors++;
                    $display("FAIL rand_latency[%0d]: got %0d exp %0d (lat=%0d)", it, n, req_latency(resp_lat) + 1, resp_lat);
                end
            end
            if (mode == 2) begin
                checks++;
                if (seen_q.size() == 0 || seen_q[0] !== a0) begin
                    errors++;
                    $display("FAIL rand_first[%0d]: got %h exp %h", it, (seen_q.size() != 0) ? seen_q[0] : 27'h0, a0);
                end
            end
            if (w0) exp_di0 = mem_model[a0[7:0]];
            if (w1) exp_di1 = mem_model[a1[7:0]];
            checks++;
            if ({c0_di, c1_di} !== {exp_di0, exp_di1}) begin
                errors++;
                $display("FAIL rand_data[%0d]: got %h/%h exp %h/%h", it, c0_di, c1_di, exp_di0, exp_di1);
            end
            c0_rd = 1'b0; c1_rd = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_watchdog();
        int n; bit ok;
        logic [26:0] a;
        resp_stuck = 1'b1;
        c1_a = 27'h55; c1_rd = 1'b1;
        wait_ready(1'b0, 1'b1, 100, n, ok);
        exp_di1 = 8'hFF;
        checks++;
        if (!ok || n !== TMO + 3) begin
            errors++;
            $display("FAIL wdog_latency: got ok=%b n=%0d exp n=%0d", ok, n, TMO + 3);
        end
        checks++;
        if ({c1_di, err_timeout, c0_di} !== {exp_di1, 1'b1, exp_di0}) begin
            errors++;
            $display("FAIL wdog_fill: got c1_di=%h err=%b c0_di=%h exp %h 1 %h", c1_di, err_timeout, c0_di, exp_di1, exp_di0);
        end
        c1_rd = 1'b0; resp_stuck = 1'b0;
        repeat (2) @(negedge clk);
        a = 27'($urandom);
        resp_lat = 2;
        c1_a = a; c1_rd = 1'b1;
        wait_ready(1'b0, 1'b1, 100, n, ok);
        exp_di1 = mem_model[a[7:0]];
        checks++;
        if (!ok || c1_di !== exp_di1 || err_timeout !== 1'b1) begin
            errors++;
            $display("FAIL wdog_sticky: got ok=%b di=%h err=%b exp 1 %h 1", ok, c1_di, err_timeout, exp_di1);
        end
        c1_rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n; bit ok;
        logic [26:0] a;
        resp_stuck = 1'b1;
        c0_a = 27'h4ABCDE; c0_rd = 1'b1;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({c0_ready, c1_ready, c0_di, c1_di, mem_a, mem_rd, err_timeout} !==
            {1'b1, 1'b1, 8'h00, 8'h00, 27'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midreset_async: got rdy=%b%b di=%h/%h a=%h rd=%b err=%b exp 11 00/00 0 0 0",
                     c0_ready, c1_ready, c0_di, c1_di, mem_a, mem_rd, err_timeout);
        end
        exp_di0 = 8'h00; exp_di1 = 8'h00;
        c0_rd = 1'b0; resp_stuck = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        a = 27'($urandom);
        resp_lat = 1;
        rd_pulses = 0;
        c0_a = a; c0_rd = 1'b1;
        wait_ready(1'b1, 1'b0, 100, n, ok);
        exp_di0 = mem_model[a[7:0]];
        checks++;
        if (!ok || rd_pulses !== 1 || c0_di !== exp_di0 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL midreset_after: got ok=%b pulses=%0d di=%h err=%b exp 1 1 %h 0",
                     ok, rd_pulses, c0_di, err_timeout, exp_di0);
        end
        c0_rd = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_model[i] = 8'($urandom);
        test_reset();
        test_single_read();
        test_priority();
        test_held();
        test_random();
        test_watchdog();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
